// File: rtl/conv_window_gen_3x3_if.sv
// conv_window_gen_3x3_if: raster pixel stream in, packed 3x3 window stream out.
// master = pixel source / kernel side, slave = window generator.
// Signals: pix_in[7:0], pix_vld, pix_sof (to slave); win_data[71:0], win_vld,
//          win_eof when WIN_EOF_EN is defined (from slave).
interface conv_window_gen_3x3_if;
  logic [7:0]  pix_in;
  logic        pix_vld;
  logic        pix_sof;
  logic [71:0] win_data;
  logic        win_vld;
`ifdef WIN_EOF_EN
  logic        win_eof;

  modport master (
    output pix_in, pix_vld, pix_sof,
    input  win_data, win_vld, win_eof
  );
  modport slave (
    input  pix_in, pix_vld, pix_sof,
    output win_data, win_vld, win_eof
  );
`else
  modport master (
    output pix_in, pix_vld, pix_sof,
    input  win_data, win_vld
  );
  modport slave (
    input  pix_in, pix_vld, pix_sof,
    output win_data, win_vld
  );
`endif
endinterface

// File: rtl/conv_window_gen_3x3.sv
// conv_window_gen_3x3: streaming 3x3 window generator (valid conv, no pad).
// Ports: sclk, s_rst_n (sync, active low), bus (slave modport):
//   pix_in/pix_vld/pix_sof in; win_data (byte 3*c+r = d_rc)/win_vld out.
// Optional: define WIN_EOF_EN to add win_eof (last window of the frame).
module conv_window_gen_3x3 #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                 sclk,
  input  logic                 s_rst_n,
  conv_window_gen_3x3_if.slave bus
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
  localparam logic [CW-1:0] MIN_COL  = CW'(2);
  localparam logic [RW-1:0] MIN_ROW  = RW'(2);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [7:0]    r_lb1 [IMG_W];
  logic [7:0]    r_lb2 [IMG_W];
  logic [7:0]    r_wa  [3];
  logic [7:0]    r_wb  [3];
  logic [71:0]   r_data;
  logic          r_vld;

  logic          w_acc;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [7:0]    w_new [3];
  logic          w_full;
  logic [71:0]   w_win;

  // sof relocates the accepted pixel to (0,0) in the same cycle
  assign w_acc  = bus.pix_vld;
  assign w_col  = bus.pix_sof ? '0 : r_col;
  assign w_row  = bus.pix_sof ? '0 : r_row;
  assign w_full = (w_col >= MIN_COL) && (w_row >= MIN_ROW);

  // incoming column, top to bottom
  assign w_new[0] = r_lb2[w_col];
  assign w_new[1] = r_lb1[w_col];
  assign w_new[2] = bus.pix_in;

  // r_wa = oldest column, r_wb = middle column
  assign w_win = {w_new[2], w_new[1], w_new[0],
                  r_wb[2],  r_wb[1],  r_wb[0],
                  r_wa[2],  r_wa[1],  r_wa[0]};

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_vld  <= 1'b0;
      r_data <= '0;
    end else begin
      r_vld <= w_acc & w_full;
      if (w_acc) begin
        if (w_col == LAST_COL) begin
          r_col <= '0;
          if (w_row == LAST_ROW) begin
            r_row <= '0;
          end else begin
            r_row <= w_row + 1'b1;
          end
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
        if (w_full) begin
          r_data <= w_win;
        end
      end
    end
  end

  // storage without reset; rows 0/1 of every frame refill it before use
  always_ff @(posedge sclk) begin
    if (s_rst_n && w_acc) begin
      r_lb2[w_col] <= r_lb1[w_col];
      r_lb1[w_col] <= bus.pix_in;
      for (int i = 0; i < 3; i++) begin
        r_wa[i] <= r_wb[i];
        r_wb[i] <= w_new[i];
      end
    end
  end

  assign bus.win_data = r_data;
  assign bus.win_vld  = r_vld;

`ifdef WIN_EOF_EN
  logic r_eof;

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      r_eof <= 1'b0;
    end else begin
      r_eof <= w_acc & w_full &
               (w_col == LAST_COL) & (w_row == LAST_ROW);
    end
  end

  assign bus.win_eof = r_eof;
`endif
endmodule

// File: tb/tb_conv_window_gen_3x3.sv
// tb_conv_window_gen_3x3: randomized and directed stimulus for the 3x3
// window generator, checked against a frame-image reference model.
module tb_conv_window_gen_3x3;
  localparam int W = 4;
  localparam int H = 4;
  localparam logic [71:0] FIRST_WIN = 72'h22_12_02_21_11_01_20_10_00;

  logic sclk;
  logic s_rst_n;
  conv_window_gen_3x3_if bus ();

  conv_window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .bus     (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int checks = 0;
  int errors = 0;

  // reference model: image of the current frame, position by pixel index
  logic [7:0]  img [H][W];
  int          p = 0;
  logic [71:0] last_data = '0;

  function automatic logic [7:0] pv(input int k);
    return 8'(16 * ((k % (W * H)) / W) + (k % W));
  endfunction

  task automatic step(input logic [7:0] pix, input logic vld,
                      input logic sof, output logic ev,
                      output logic [71:0] ed, output logic ee);
    int row, col;
    bus.pix_in  = pix;
    bus.pix_vld = vld;
    bus.pix_sof = sof;
    @(posedge sclk);
    #1;
    ev = 1'b0;
    ee = 1'b0;
    if (vld) begin
      if (sof) p = 0;
      row = p / W;
      col = p % W;
      img[row][col] = pix;
      if (row >= 2 && col >= 2) begin
        ev = 1'b1;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            last_data[(3*c+r)*8 +: 8] = img[row-2+r][col-2+c];
        ee = (row == H - 1) && (col == W - 1);
      end
      p = (p + 1) % (W * H);
    end
    ed = last_data;
    bus.pix_vld = 1'b0;
    bus.pix_sof = 1'b0;
  endtask

  task automatic apply_reset();
    s_rst_n = 1'b0;
    bus.pix_vld = 1'b0;
    bus.pix_sof = 1'b0;
    @(posedge sclk);
    #1;
    s_rst_n = 1'b1;
    p = 0;
    last_data = '0;
  endtask

  task automatic test_reset();
    bus.pix_in = '0;
    apply_reset();
    apply_reset();
    checks++;
    if (bus.win_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_vld got=%b exp=0", bus.win_vld);
    end
    checks++;
    if (bus.win_data !== 72'h0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", bus.win_data);
    end
`ifdef WIN_EOF_EN
    checks++;
    if (bus.win_eof !== 1'b0) begin
      errors++;
      $display("FAIL reset_eof got=%b exp=0", bus.win_eof);
    end
`endif
  endtask

  task automatic test_single_frame();
    logic ev, ee;
    logic [71:0] ed;
    int n = 0;
    for (int k = 0; k < W * H + 2; k++) begin
      if (k < W * H) step(pv(k), 1'b1, k == 0, ev, ed, ee);
      else step(8'($urandom), 1'b0, 1'b0, ev, ed, ee);
      checks++;
      if (bus.win_vld !== ev) begin
        errors++;
        $display("FAIL single_vld k=%0d got=%b exp=%b", k, bus.win_vld, ev);
      end
      checks++;
      if (bus.win_data !== ed) begin
        errors++;
        $display("FAIL single_data k=%0d got=%h exp=%h", k, bus.win_data, ed);
      end
`ifdef WIN_EOF_EN
      checks++;
      if (bus.win_eof !== ee) begin
        errors++;
        $display("FAIL single_eof k=%0d got=%b exp=%b", k, bus.win_eof, ee);
      end
`endif
      if (bus.win_vld === 1'b1) begin
        n++;
        if (n == 1) begin
          checks++;
          if (bus.win_data !== FIRST_WIN) begin
            errors++;
            $display("FAIL single_first got=%h exp=%h", bus.win_data, FIRST_WIN);
          end
        end
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL single_count got=%0d exp=4", n);
    end
  endtask

  task automatic test_gaps();
    logic ev, ee;
    logic [71:0] ed;
    int n = 0;
    for (int k = 0; k < 2 * W * H; k++) begin
      if (k % 2 == 0) step(pv(k / 2), 1'b1, k == 0, ev, ed, ee);
      else step(8'($urandom), 1'b0, 1'b0, ev, ed, ee);
      checks++;
      if (bus.win_vld !== ev) begin
        errors++;
        $display("FAIL gaps_vld k=%0d got=%b exp=%b", k, bus.win_vld, ev);
      end
      checks++;
      if (bus.win_data !== ed) begin
        errors++;
        $display("FAIL gaps_data k=%0d got=%h exp=%h", k, bus.win_data, ed);
      end
`ifdef WIN_EOF_EN
      checks++;
      if (bus.win_eof !== ee) begin
        errors++;
        $display("FAIL gaps_eof k=%0d got=%b exp=%b", k, bus.win_eof, ee);
      end
`endif
      if (bus.win_vld === 1'b1) n++;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL gaps_count got=%0d exp=4", n);
    end
  endtask

  task automatic test_back_to_back();
    logic ev, ee;
    logic [71:0] ed;
    int n = 0;
    for (int k = 0; k < 2 * W * H; k++) begin
      step(pv(k), 1'b1, k == 0, ev, ed, ee);
      checks++;
      if (bus.win_vld !== ev) begin
        errors++;
        $display("FAIL b2b_vld k=%0d got=%b exp=%b", k, bus.win_vld, ev);
      end
      checks++;
      if (bus.win_data !== ed) begin
        errors++;
        $display("FAIL b2b_data k=%0d got=%h exp=%h", k, bus.win_data, ed);
      end
      if (bus.win_vld === 1'b1) begin
        n++;
        if (n == 5) begin
          checks++;
          if (bus.win_data !== FIRST_WIN) begin
            errors++;
            $display("FAIL b2b_frame2_first got=%h exp=%h", bus.win_data, FIRST_WIN);
          end
        end
      end
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=8", n);
    end
  endtask

  task automatic test_mid_sof();
    logic ev, ee;
    logic [71:0] ed;
    int n = 0;
    // old frame up to (2,0), then sof where (2,1) would have been
    for (int k = 0; k < 9 + W * H; k++) begin
      if (k < 9) step(8'($urandom), 1'b1, k == 0, ev, ed, ee);
      else step(pv(k - 9), 1'b1, k == 9, ev, ed, ee);
      checks++;
      if (bus.win_vld !== ev) begin
        errors++;
        $display("FAIL midsof_vld k=%0d got=%b exp=%b", k, bus.win_vld, ev);
      end
      checks++;
      if (bus.win_data !== ed) begin
        errors++;
        $display("FAIL midsof_data k=%0d got=%h exp=%h", k, bus.win_data, ed);
      end
      if (bus.win_vld === 1'b1) begin
        n++;
        if (n == 1) begin
          checks++;
          if (bus.win_data !== FIRST_WIN) begin
            errors++;
            $display("FAIL midsof_first got=%h exp=%h", bus.win_data, FIRST_WIN);
          end
        end
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL midsof_count got=%0d exp=4", n);
    end
  endtask

  task automatic test_reset_mid();
    logic ev, ee;
    logic [71:0] ed;
    int n = 0;
    for (int k = 0; k <= 2 * W + 2; k++) begin
      step(pv(k), 1'b1, k == 0, ev, ed, ee);
    end
    checks++;
    if (bus.win_vld !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre_vld got=%b exp=1", bus.win_vld);
    end
    apply_reset();
    checks++;
    if (bus.win_vld !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_vld got=%b exp=0", bus.win_vld);
    end
    checks++;
    if (bus.win_data !== 72'h0) begin
      errors++;
      $display("FAIL rstmid_data got=%h exp=0", bus.win_data);
    end
    for (int k = 0; k < W * H; k++) begin
      step(pv(k), 1'b1, 1'b0, ev, ed, ee);
      checks++;
      if (bus.win_vld !== ev) begin
        errors++;
        $display("FAIL rstmid_post_vld k=%0d got=%b exp=%b", k, bus.win_vld, ev);
      end
      checks++;
      if (bus.win_data !== ed) begin
        errors++;
        $display("FAIL rstmid_post_data k=%0d got=%h exp=%h", k, bus.win_data, ed);
      end
      if (bus.win_vld === 1'b1) begin
        n++;
        if (n == 1) begin
          checks++;
          if (bus.win_data !== FIRST_WIN) begin
            errors++;
            $display("FAIL rstmid_first got=%h exp=%h", bus.win_data, FIRST_WIN);
          end
        end
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL rstmid_count got=%0d exp=4", n);
    end
  endtask

  task automatic test_random();
    logic ev, ee, vld, sof;
    logic [71:0] ed;
    for (int k = 0; k < 400; k++) begin
      vld = ($urandom % 3) != 0;
      sof = vld && (($urandom % 40) == 0);
      step(8'($urandom), vld, sof, ev, ed, ee);
      checks++;
      if (bus.win_vld !== ev) begin
        errors++;
        $display("FAIL rand_vld k=%0d got=%b exp=%b", k, bus.win_vld, ev);
      end
      checks++;
      if (bus.win_data !== ed) begin
        errors++;
        $display("FAIL rand_data k=%0d got=%h exp=%h", k, bus.win_data, ed);
      end
`ifdef WIN_EOF_EN
      checks++;
      if (bus.win_eof !== ee) begin
        errors++;
        $display("FAIL rand_eof k=%0d got=%b exp=%b", k, bus.win_eof, ee);
      end
`endif
    end
  endtask

  initial begin
    s_rst_n = 1'b0;
    bus.pix_in = '0;
    bus.pix_vld = 1'b0;
    bus.pix_sof = 1'b0;
    test_reset();
    test_single_frame();
    test_gaps();
    test_back_to_back();
    test_mid_sof();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
